// File: rtl/shift_subtract_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor takes a one-edge path that reports all-ones quotient and div_by_zero.
module shift_subtract_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  state_e        r_state,   w_state_nxt;
  logic [DW-1:0] r_sreg,    w_sreg_nxt;
  logic [VW:0]   r_rem,     w_rem_nxt;
  logic [VW-1:0] r_divisor, w_divisor_nxt;
  logic [CW-1:0] r_cnt,     w_cnt_nxt;
  logic          r_dz,      w_dz_nxt;
  logic [DW-1:0] r_quot,    w_quot_nxt;
  logic [VW-1:0] r_remo,    w_remo_nxt;
  logic          r_dbz,     w_dbz_nxt;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [VW:0]   w_trial;
  logic          w_ge;
  logic [VW:0]   w_rem_step;
  logic [DW-1:0] w_sreg_step;

  // Single-iteration datapath (unsigned, VW+1 bits so the compare cannot overflow)
  always_comb begin
    w_trial     = {r_rem[VW-1:0], r_sreg[DW-1]};
    w_ge        = (w_trial >= {1'b0, r_divisor});
    w_rem_step  = w_ge ? (w_trial - {1'b0, r_divisor}) : w_trial;
    w_sreg_step = {r_sreg[DW-2:0], w_ge};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_dz      <= 1'b0;
      r_quot    <= '0;
      r_remo    <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_sreg    <= w_sreg_nxt;
      r_rem     <= w_rem_nxt;
      r_divisor <= w_divisor_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dz      <= w_dz_nxt;
      r_quot    <= w_quot_nxt;
      r_remo    <= w_remo_nxt;
      r_dbz     <= w_dbz_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt   = r_state;
    w_sreg_nxt    = r_sreg;
    w_rem_nxt     = r_rem;
    w_divisor_nxt = r_divisor;
    w_cnt_nxt     = r_cnt;
    w_dz_nxt      = r_dz;
    w_quot_nxt    = r_quot;
    w_remo_nxt    = r_remo;
    w_dbz_nxt     = r_dbz;

    case (r_state)
      // FIN accepts start exactly like IDLE so operations can run back to back.
      StIdle, StFin: begin
        if (start) begin
          w_state_nxt   = StRun;
          w_sreg_nxt    = dividend;
          w_rem_nxt     = '0;
          w_divisor_nxt = divisor;
          // A zero divisor spends a single hidden RUN cycle (busy stays low)
          // so its done pulse lands one edge after acceptance.
          w_dz_nxt      = (divisor == '0);
          w_cnt_nxt     = (divisor == '0) ? '0 : CW'(DW - 1);
        end else begin
          w_state_nxt = StIdle;
        end
      end

      StRun: begin
        if (r_dz) begin
          w_state_nxt = StFin;
          w_quot_nxt  = '1;
          w_remo_nxt  = '0;
          w_dbz_nxt   = 1'b1;
        end else begin
          w_sreg_nxt = w_sreg_step;
          w_rem_nxt  = w_rem_step;
          if (r_cnt == '0) begin
            w_state_nxt = StFin;
            w_quot_nxt  = w_sreg_step;
            // Final remainder is below the divisor, so the top bit is always zero.
            w_remo_nxt  = w_rem_step[VW-1:0];
            w_dbz_nxt   = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Outputs come straight from registers; no input-to-output combinational path.
  assign busy        = (r_state == StRun) && !r_dz;
  assign done        = (r_state == StFin);
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Self-checking bench: directed steps plus an exhaustive sweep, scoreboard of expected results.
module tb_shift_subtract_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;

  shift_subtract_divider #(
    .DW(8),
    .VW(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [2:0] b;
    logic [7:0] q;
    logic [2:0] r;
    logic       dz;
    int         t;   // cycle count at which done must be observed
    int         bl;  // expected number of busy cycles before done
  } exp_t;

  exp_t       sb[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         busy_run = 0;
  logic [7:0] held_q  = '0;
  logic [2:0] held_r  = '0;
  logic       held_dz = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Output monitor: pops the scoreboard on every done pulse, checks hold behaviour otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
      held_q   = '0;
      held_r   = '0;
      held_dz  = 1'b0;
    end else begin
      chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient", {24'd0, quotient}, {24'd0, e.q});
          chk("remainder", {29'd0, remainder}, {29'd0, e.r});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
          chk("latency", cyc, e.t);
          chk("busy_cycles", busy_run, e.bl);
          if (e.b != 0) begin
            chk("invariant", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
            chk("rem_lt_div", {31'd0, remainder < e.b}, 32'd1);
          end
          held_q  = e.q;
          held_r  = e.r;
          held_dz = e.dz;
        end
        busy_run = 0;
      end else begin
        chk("held_quotient", {24'd0, quotient}, {24'd0, held_q});
        chk("held_remainder", {29'd0, remainder}, {29'd0, held_r});
        chk("held_dbz", {31'd0, div_by_zero}, {31'd0, held_dz});
      end
    end
  end

  // Drive one start cycle from the current negedge; push an expectation if it will be accepted.
  task automatic issue(input logic [7:0] a, input logic [2:0] b, input bit accept);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (accept) begin
      e.a  = a;
      e.b  = b;
      e.q  = (b == 0) ? 8'hFF : a / b;
      e.r  = (b == 0) ? 3'd0 : 3'(a % b);
      e.dz = (b == 0);
      e.t  = cyc + ((b == 0) ? 2 : 9);
      e.bl = (b == 0) ? 0 : 8;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("idle_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {29'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;

    // Basic divides, including boundary operands
    @(negedge clk); issue(8'd105, 3'd7, 1'b1); wait_idle();
    @(negedge clk); issue(8'd100, 3'd7, 1'b1); wait_idle();
    @(negedge clk); issue(8'd255, 3'd1, 1'b1); wait_idle();
    @(negedge clk); issue(8'd0,   3'd5, 1'b1); wait_idle();
    @(negedge clk); issue(8'd42,  3'd0, 1'b1); wait_idle();

    // Start while busy is ignored; start during done is accepted back to back
    @(negedge clk); issue(8'd100, 3'd7, 1'b1);
    @(negedge clk); issue(8'd9, 3'd3, 1'b0);
    dividend = 8'd77;
    divisor  = 3'd2;
    wait_done();
    issue(8'd9, 3'd3, 1'b1);
    wait_idle();

    // Divide by zero straight after a normal completion
    @(negedge clk); issue(8'd200, 3'd3, 1'b1);
    wait_done();
    issue(8'd17, 3'd0, 1'b1);
    wait_idle();

    // Reset mid-operation: outputs clear immediately, no done follows
    @(negedge clk); issue(8'd200, 3'd6, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", {24'd0, quotient}, 32'd0);
    chk("midrst_remainder", {29'd0, remainder}, 32'd0);
    chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    @(negedge clk); issue(8'd200, 3'd6, 1'b1); wait_idle();

    // Exhaustive sweep of nonzero divisors
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 8; b++) begin
        @(negedge clk);
        issue(8'(a), 3'(b), 1'b1);
        wait_idle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_subtract_divider.md
Name: shift_subtract_divider

Overview:
- Sequential restoring shift-and-subtract divider; the inverse of the add-shift multiplier datapath.
- Divides an 8-bit product-width dividend by a 3-bit multiplier-width divisor, producing one quotient bit per clock.
- Start/busy/done handshake. Outputs feed the existing seven-segment display controller or a self-check path that recovers A from P = A*B.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 3, divisor and remainder width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk only when busy=0.
- dividend  input  DW  numerator; captured when start is accepted.
- divisor  input  VW  denominator; captured when start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results update.
- quotient  output  DW  floor(dividend/divisor); held until the next completion.
- remainder  output  VW  dividend mod divisor; held until the next completion.
- div_by_zero  output  1  set with done when the captured divisor==0; held with the results.

Behaviour:
- Reset is asynchronous and active-low. rst_n=0 immediately forces:
  - state=IDLE;
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0;
  - all internal registers cleared.
- Reset mid-operation aborts the division; no done pulse follows.
- States:
  - IDLE: wait for start.
  - RUN: iterate.
  - FIN: one cycle, drives the done pulse.
- IDLE->RUN: start=1 at edge N with divisor!=0.
  - Capture shift register = dividend, partial remainder = 0 (VW+1 bits), iteration counter = DW-1.
  - busy=1 after edge N.
- IDLE->FIN: start=1 at edge N with divisor==0.
  - At edge N+1: quotient = all ones (255 at default DW), remainder = 0, div_by_zero=1, done=1, busy=0.
- RUN, each edge:
  - r' = {r[VW-1:0], sreg[DW-1]} (VW+1 bits).
  - sreg shifts left by one.
  - If r' >= {1'b0, divisor}: r = r' - divisor and shift in quotient bit 1. Else r = r' and shift in 0.
  - The compare is unsigned, VW+1 bits wide, and never overflows.
- Counter reaches 0 on the DW-th RUN edge (edge N+DW). On that edge:
  - quotient and remainder are loaded from the final values;
  - div_by_zero=0, done=1, busy=0;
  - state=FIN.
- Latency, start to done: DW edges for a normal divide, 1 edge for divide by zero.
- FIN: done=1 for exactly one cycle, busy=0.
  - start accepted in FIN behaves exactly as in IDLE, giving back-to-back operations with no dead cycle.
  - Otherwise FIN->IDLE and done falls.
- start while busy=1 is ignored; captured operands are unaffected.
- Operand inputs may change freely after acceptance.
- quotient, remainder and div_by_zero change only on completion or reset; otherwise they are held indefinitely.
- done and busy are never high together.
- Arithmetic invariant for divisor!=0: quotient*divisor + remainder == dividend, with remainder < divisor.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset released, dividend=105, divisor=7, one-cycle start:
  - busy high for 8 cycles;
  - done pulse 8 edges after start;
  - quotient=15, remainder=0, div_by_zero=0.
- dividend=100, divisor=7 -> quotient=14, remainder=2.
- dividend=255, divisor=1 -> quotient=255, remainder=0.
- dividend=0, divisor=5 -> quotient=0, remainder=0.
- dividend=42, divisor=0:
  - done one edge after start, busy never high;
  - quotient=255, remainder=0, div_by_zero=1.
- Protocol stress:
  - start 100/7;
  - at cycle 3 assert start with 9/3 and change the operands -> ignored, result is 14 r 2;
  - assert start with 9/3 during the done cycle -> accepted, second done 8 edges later with quotient=3, remainder=0.
- Reset mid-operation:
  - start 200/6, drop rst_n at cycle 4 -> all outputs 0 immediately, no done pulse;
  - after release, 200/6 -> quotient=33, remainder=2.
- Exhaustive sweep, dividend 0..255 x divisor 1..7: check the arithmetic invariant and 8-edge latency on every operation.
